// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Transmit side of the systolic array's North/West boundary. Each accepted
// beat carries one unskewed k-slice: column k of A (one value per array row)
// and row k of B (one value per array column). The slice is launched into
// per-lane delay lines so that lane i appears i cycles later than lane 0,
// producing the diagonal wavefront the array expects. Cycles without a
// transfer travel through the same delay lines as zero diagonals, so the
// relative skew between lanes is kept even when the source stalls.
//
// One start_i runs one full k_len-deep pass:
//   IDLE -> STREAM (accept k_len beats) -> FLUSH (N cycles) -> DONE -> IDLE
//
// Ports
//   clk_i           single clock, rising edge
//   rstn_i          asynchronous active-low reset
//   start_i         begin a pass (sampled only in IDLE)
//   k_len_i         beats in this pass, latched on start, clamped to K_MAX
//   in_valid_i      a_vec_i / b_vec_i hold a valid k-slice
//   in_ready_o      feeder accepts the slice (high only in STREAM)
//   a_vec_i[r]      A[r][k]
//   b_vec_i[c]      B[k][c]
//   west_o[r]       to array west input, lane r delayed by r cycles
//   north_o[c]      to array north input, lane c delayed by c cycles
//   inputs_valid_o  lane-0 valid strobe
//   busy_o          FSM not in IDLE
//   done_o          one-cycle pulse at end of pass
//   stall_cnt_o     STREAM cycles with in_valid_i low (current/last pass)
//
// Build option
//   FEEDER_STALL_CNT_EN  when defined, stall_cnt_o is a saturating 32-bit
//                        bubble counter; otherwise it is tied to zero and
//                        no counter logic is built.
// -----------------------------------------------------------------------------
module systolic_feeder #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int K_MAX      = 256,
    localparam int K_W       = $clog2(K_MAX + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [K_W-1:0]        k_len_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_vec_i [0:N-1],
    input  logic [DATA_WIDTH-1:0] b_vec_i [0:N-1],
    output logic [DATA_WIDTH-1:0] west_o  [0:N-1],
    output logic [DATA_WIDTH-1:0] north_o [0:N-1],
    output logic                  inputs_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           stall_cnt_o
);

    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [K_W-1:0]  k_len_q;
    logic [K_W-1:0]  beat_cnt_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [K_W-1:0]  k_len_clamped;
    logic            transfer;
    logic            start_accept;

    // Delay lines: every lane carries N stages; lane i taps stage i, the
    // deeper stages of shorter lanes are never observed and trim away.
    logic [DATA_WIDTH-1:0] a_q [0:N-1][0:N-1];
    logic [DATA_WIDTH-1:0] b_q [0:N-1][0:N-1];
    // Valid travels identically for all lanes, so one shift register
    // serves them all: bit i is the valid of every lane's stage i.
    logic [N-1:0]          vld_q;

    assign k_len_clamped = (k_len_i > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len_i;
    assign transfer      = in_valid_i & in_ready_o;
    assign start_accept  = (state_q == S_IDLE) & start_i;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register in the design
            // samples pre-edge values, independent of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first; every path then assigns both outputs, so no
        // latch is inferred.
        state_d    = state_q;
        in_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (k_len_i == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready_o = 1'b1;
                if (in_valid_i && (beat_cnt_q == k_len_q - K_W'(1))) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Hold off new data for N cycles so the deepest lane drains.
                if (flush_cnt_q == FW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (start_accept) begin
                k_len_q    <= k_len_clamped;
                beat_cnt_q <= '0;
            end else if (transfer) begin
                beat_cnt_q <= beat_cnt_q + K_W'(1);
            end
            flush_cnt_q <= (state_q == S_FLUSH) ? flush_cnt_q + FW'(1) : '0;
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_STREAM) && !in_valid_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    // --------------------------------------------------------- delay lines
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: these are flop-based delay lines, not RAM, so clearing
            // them on reset is cheap and guarantees zero lanes afterwards.
            vld_q <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
        end else begin
            vld_q[0] <= transfer;
            for (int j = 1; j < N; j++) begin
                vld_q[j] <= vld_q[j-1];
            end
            for (int i = 0; i < N; i++) begin
                a_q[i][0] <= transfer ? a_vec_i[i] : '0;
                b_q[i][0] <= transfer ? b_vec_i[i] : '0;
                for (int j = 1; j < N; j++) begin
                    a_q[i][j] <= a_q[i][j-1];
                    b_q[i][j] <= b_q[i][j-1];
                end
            end
        end
    end

    // Lane i is tapped at stage i and masked by that stage's valid bit.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            west_o[i]  = vld_q[i] ? a_q[i][i] : '0;
            north_o[i] = vld_q[i] ? b_q[i][i] : '0;
        end
    end

    assign inputs_valid_o = vld_q[0];

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//
// Scoreboard bench. The driver pushes, for every accepted slice, the value
// each lane must show and the cycle it must show it; it also pushes the
// cycle in which done_o must pulse. A monitor running on the falling edge
// pops entries when their cycle arrives and otherwise requires zero.
//
// Cycle bookkeeping: cyc counts rising edges. A slice accepted at rising
// edge t must be visible on lane r during the low phase after edge t+r.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int K_MAX = 256;
    localparam int K_W   = $clog2(K_MAX + 1);

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic           start_i = 1'b0;
    logic [K_W-1:0] k_len_i = '0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [DW-1:0]  a_vec_i [0:N-1];
    logic [DW-1:0]  b_vec_i [0:N-1];
    logic [DW-1:0]  west_o  [0:N-1];
    logic [DW-1:0]  north_o [0:N-1];
    logic           inputs_valid_o;
    logic           busy_o;
    logic           done_o;
    logic [31:0]    stall_cnt_o;

    systolic_feeder #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .k_len_i        (k_len_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .a_vec_i        (a_vec_i),
        .b_vec_i        (b_vec_i),
        .west_o         (west_o),
        .north_o        (north_o),
        .inputs_valid_o (inputs_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [DW-1:0] d;
    } exp_t;

    exp_t west_q  [N][$];
    exp_t north_q [N][$];
    int   iv_q[$];
    int   done_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_queues();
        for (int r = 0; r < N; r++) begin
            west_q[r].delete();
            north_q[r].delete();
        end
        iv_q.delete();
        done_q.delete();
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk_i) begin
        if (mon_en) begin
            for (int r = 0; r < N; r++) begin
                if (west_q[r].size() > 0 && west_q[r][0].at == cyc) begin
                    check($sformatf("west%0d", r), west_o[r], west_q[r][0].d);
                    void'(west_q[r].pop_front());
                end else begin
                    check($sformatf("west%0d_zero", r), west_o[r], '0);
                end
                if (north_q[r].size() > 0 && north_q[r][0].at == cyc) begin
                    check($sformatf("north%0d", r), north_o[r], north_q[r][0].d);
                    void'(north_q[r].pop_front());
                end else begin
                    check($sformatf("north%0d_zero", r), north_o[r], '0);
                end
            end
            if (iv_q.size() > 0 && iv_q[0] == cyc) begin
                check("inputs_valid", inputs_valid_o, 1);
                void'(iv_q.pop_front());
            end else begin
                check("inputs_valid_idle", inputs_valid_o, 0);
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                check("done_pulse", done_o, 1);
                void'(done_q.pop_front());
            end else begin
                check("done_idle", done_o, 0);
            end
        end
    end

    // ------------------------------------------------------------- driver
    function automatic logic [DW-1:0] a_val(input int mode, input int k, input int r);
        if (mode == 0) return DW'(k + 1);
        return 32'hA000_0000 | DW'(r << 16) | DW'(k + 1);
    endfunction

    function automatic logic [DW-1:0] b_val(input int mode, input int k, input int c);
        if (mode == 0) return DW'(k + 1);
        return 32'hB000_0000 | DW'(c << 16) | DW'(k + 1);
    endfunction

    task automatic zero_inputs();
        for (int r = 0; r < N; r++) begin
            a_vec_i[r] = '0;
            b_vec_i[r] = '0;
        end
    endtask

    task automatic offer_beat(input int mode, input int k);
        int tl;
        in_valid_i = 1'b1;
        for (int r = 0; r < N; r++) begin
            a_vec_i[r] = a_val(mode, k, r);
            b_vec_i[r] = b_val(mode, k, r);
        end
        tl = cyc + 1;
        iv_q.push_back(tl);
        for (int r = 0; r < N; r++) begin
            west_q[r].push_back('{at: tl + r, d: a_vec_i[r]});
            north_q[r].push_back('{at: tl + r, d: b_vec_i[r]});
        end
    endtask

    // Called on a falling edge. gap_at: beat index preceded by one idle
    // STREAM cycle (-1 for none). repulse: hold start_i high (with a bogus
    // k_len) for the rest of the pass.
    task automatic run_pass(input int klen, input int gap_at, input bit repulse,
                            input int exp_xfers, input int exp_stalls, input int mode);
        int ts;
        int tl;
        int waits;
        logic [31:0] exp_sc;
        start_i = 1'b1;
        k_len_i = K_W'(klen);
        ts = cyc + 1;
        if (exp_xfers == 0) done_q.push_back(ts);
        @(negedge clk_i);
        start_i = repulse;
        if (repulse) k_len_i = K_W'(1);
        check("busy_after_start", busy_o, 1);
        if (exp_xfers == 0) check("ready_k0", in_ready_o, 0);
        tl = ts;
        for (int k = 0; k < exp_xfers; k++) begin
            if (k == gap_at) begin
                in_valid_i = 1'b0;
                zero_inputs();
                @(negedge clk_i);
            end
            waits = 0;
            while (!in_ready_o && waits < 20) begin
                @(negedge clk_i);
                waits++;
            end
            if (!in_ready_o) begin
                check("ready_timeout", in_ready_o, 1);
                break;
            end
            offer_beat(mode, k);
            tl = cyc + 1;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        zero_inputs();
        if (exp_xfers > 0) begin
            done_q.push_back(tl + N);
            check("ready_after_last", in_ready_o, 0);
        end
        waits = 0;
        while (!done_o && waits < 300) begin
            @(negedge clk_i);
            waits++;
        end
        if (!done_o) check("done_timeout", done_o, 1);
        start_i = 1'b0;
        k_len_i = '0;
`ifdef FEEDER_STALL_CNT_EN
        exp_sc = 32'(exp_stalls);
`else
        exp_sc = 32'd0;
`endif
        check("stall_cnt", stall_cnt_o, exp_sc);
        @(negedge clk_i);
        check("busy_after_done", busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();
        #1;
        // Reset state
        for (int r = 0; r < N; r++) begin
            check($sformatf("rst_west%0d", r), west_o[r], '0);
            check($sformatf("rst_north%0d", r), north_o[r], '0);
        end
        check("rst_ready", in_ready_o, 0);
        check("rst_iv", inputs_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);

        // 1: basic three-beat pass, identical values on every lane
        run_pass(3, -1, 1'b0, 3, 0, 0);
        // 2: one bubble before the second beat
        run_pass(3, 1, 1'b0, 3, 1, 1);
        // 3: empty pass
        run_pass(0, -1, 1'b0, 0, 0, 1);
        // 4: start held during STREAM/FLUSH/DONE is ignored; back-to-back pass
        run_pass(4, -1, 1'b1, 4, 0, 1);
        run_pass(2, -1, 1'b0, 2, 0, 0);

        // 5: reset in the middle of a pass
        start_i = 1'b1;
        k_len_i = K_W'(5);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            offer_beat(1, k);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        zero_inputs();
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        clear_queues();
        #1;
        for (int r = 0; r < N; r++) begin
            check($sformatf("midrst_west%0d", r), west_o[r], '0);
            check($sformatf("midrst_north%0d", r), north_o[r], '0);
        end
        check("midrst_busy", busy_o, 0);
        check("midrst_iv", inputs_valid_o, 0);
        check("midrst_ready", in_ready_o, 0);
        @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b1;
        @(negedge clk_i);
        run_pass(1, -1, 1'b0, 1, 0, 1);

        // 6: oversize k_len clamps to K_MAX
        run_pass(K_MAX + 5, -1, 1'b0, K_MAX, 0, 1);

        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
